// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Captures one byte per rising edge of rx_ready into a first-word-fall-through
// FIFO and drains it with a valid/ready handshake. Bytes that arrive while the
// FIFO is full are dropped. Each drop sets a sticky overflow flag and bumps a
// saturating drop counter.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   rx_data, rx_ready    receiver parallel byte and data-ready level
//   rd_data, rd_valid    head-of-FIFO byte, FIFO non-empty
//   rd_ready             consumer accepts rd_data this cycle
//   flush                synchronous discard of all contents
//   ovf_clear            clears overflow and drop_count
//   count                occupancy, 0..2^DEPTH_LOG2
//   full, almost_full    occupancy flags
//   overflow, drop_count sticky drop flag and saturating drop counter
module uart_rx_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic                  rx_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    input  logic                  flush,
    input  logic                  ovf_clear,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DCW   = 8;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_n, rd_ptr_n;
    logic          rx_ready_q;
    logic          push_req, push, pop, drop;

    // One request per receiver completion, however long rx_ready is held
    assign push_req = rx_ready & ~rx_ready_q;

    assign rd_valid    = (count != '0);
    assign full        = (count == PW'(DEPTH));
    assign almost_full = (count >= PW'(AF_LEVEL));
    assign rd_data     = mem[rd_ptr[DEPTH_LOG2-1:0]];

    assign pop  = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push = push_req & (~full | pop);
    // A flush discards a coincident request silently; it does not count as a drop
    assign drop = push_req & full & ~pop & ~flush;

    // Next pointer values; flush overrides push and pop
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end else begin
            if (push) wr_ptr_n = wr_ptr + PW'(1);
            if (pop)  rd_ptr_n = rd_ptr + PW'(1);
        end
    end

    // Edge detector, pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_ready_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            rx_ready_q <= rx_ready;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            count      <= wr_ptr_n - rd_ptr_n;
        end
    end

    // Storage array; not reset
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    // Overflow tracking; a drop in the same cycle as ovf_clear wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clear) begin
                drop_count <= DCW'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + DCW'(1);
            end
        end else if (ovf_clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule
